// File: rtl/acc_unit.sv
// Accumulator with load/clear/inc/dec, multi-cycle 1-bit-per-cycle shifter and R capture register.
// Single-cycle ops; k-bit shift holds busy for k cycles and pulses done on the cycle after; no backpressure.
module acc_unit #(
  parameter int         N    = 16,
  parameter bit         SAT  = 1'b0,
  parameter logic [3:0] R_ID = 4'd13,
  parameter int         SW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_en,
  input  logic [3:0]    read_en,
  input  logic [N-1:0]  datain,
  input  logic [N-1:0]  alu_out,
  input  logic          alu_to_ac,
  input  logic          inc_en,
  input  logic          dec_en,
  input  logic          clr_en,
  input  logic          shift_start,
  input  logic          shift_dir,
  input  logic [SW-1:0] shift_amt,
  output logic [N-1:0]  dataout,
  output logic [N-1:0]  r_out,
  output logic          z_flag,
  output logic          c_flag,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [N-1:0]  ACC_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  ACC_ONES = {N{1'b1}};
  localparam logic [SW-1:0] CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};

  state_t        state;
  logic [N-1:0]  acc;
  logic [SW-1:0] cnt;
  logic          dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      c_flag <= 1'b0;
      cnt    <= '0;
      dir    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (alu_to_ac) begin
            acc    <= alu_out;
            c_flag <= 1'b0;
          end else if (write_en) begin
            acc    <= datain;
            c_flag <= 1'b0;
          end else if (clr_en) begin
            acc    <= '0;
            c_flag <= 1'b0;
          end else if (shift_start) begin
            // A zero-length shift completes immediately without touching acc or c_flag.
            if (shift_amt == '0) begin
              done <= 1'b1;
            end else begin
              cnt   <= shift_amt;
              dir   <= shift_dir;
              state <= SHIFT;
            end
          end else if (inc_en && !dec_en) begin
            if (acc == ACC_ONES) begin
              c_flag <= 1'b1;
              if (!SAT) acc <= '0;
            end else begin
              acc    <= acc + ACC_ONE;
              c_flag <= 1'b0;
            end
          end else if (dec_en && !inc_en) begin
            if (acc == '0) begin
              c_flag <= 1'b1;
              if (!SAT) acc <= ACC_ONES;
            end else begin
              acc    <= acc - ACC_ONE;
              c_flag <= 1'b0;
            end
          end
        end
        SHIFT: begin
          // Only clear can interrupt a shift; every other op is ignored until it finishes.
          if (clr_en) begin
            acc    <= '0;
            c_flag <= 1'b0;
            state  <= IDLE;
          end else begin
            if (dir) begin
              acc    <= {1'b0, acc[N-1:1]};
              c_flag <= acc[0];
            end else begin
              acc    <= {acc[N-2:0], 1'b0};
              c_flag <= acc[N-1];
            end
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= '0;
    else if (read_en == R_ID) r_out <= datain;
  end

  assign dataout = acc;
  assign z_flag  = (acc == '0);
  assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_acc_unit.sv
// Drives a wrapping (SAT=0) and a saturating (SAT=1) 8-bit acc_unit with shared stimulus,
// comparing both against an arithmetic reference model every cycle.
module tb_acc_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en, alu_to_ac, inc_en, dec_en, clr_en, shift_start, shift_dir;
  logic [3:0] read_en;
  logic [7:0] datain, alu_out;
  logic [2:0] shift_amt;

  logic [7:0] dout [2];
  logic [7:0] rout [2];
  logic       z    [2];
  logic       c    [2];
  logic       bsy  [2];
  logic       dn   [2];

  int total = 0;
  int bad   = 0;

  int m_acc  [2];
  int m_c    [2];
  int m_rem  [2];
  int m_dir  [2];
  int m_done [2];
  int m_r    [2];

  always #5 clk = ~clk;

  acc_unit #(.N(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .datain(datain),
    .alu_out(alu_out), .alu_to_ac(alu_to_ac), .inc_en(inc_en), .dec_en(dec_en),
    .clr_en(clr_en), .shift_start(shift_start), .shift_dir(shift_dir), .shift_amt(shift_amt),
    .dataout(dout[0]), .r_out(rout[0]), .z_flag(z[0]), .c_flag(c[0]), .busy(bsy[0]), .done(dn[0])
  );

  acc_unit #(.N(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .datain(datain),
    .alu_out(alu_out), .alu_to_ac(alu_to_ac), .inc_en(inc_en), .dec_en(dec_en),
    .clr_en(clr_en), .shift_start(shift_start), .shift_dir(shift_dir), .shift_amt(shift_amt),
    .dataout(dout[1]), .r_out(rout[1]), .z_flag(z[1]), .c_flag(c[1]), .busy(bsy[1]), .done(dn[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 0; m_c[s] = 0; m_rem[s] = 0; m_dir[s] = 0; m_done[s] = 0; m_r[s] = 0;
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs currently applied.
  task automatic step_model();
    if (rst) begin
      reset_model();
      return;
    end
    for (int s = 0; s < 2; s++) begin
      m_done[s] = 0;
      if (read_en == 4'd13) m_r[s] = int'(datain);
      if (m_rem[s] > 0) begin
        if (clr_en) begin
          m_acc[s] = 0; m_c[s] = 0; m_rem[s] = 0;
        end else begin
          if (m_dir[s] == 0) begin
            m_c[s]   = (m_acc[s] / 128) % 2;
            m_acc[s] = (m_acc[s] * 2) % 256;
          end else begin
            m_c[s]   = m_acc[s] % 2;
            m_acc[s] = m_acc[s] / 2;
          end
          m_rem[s]--;
          if (m_rem[s] == 0) m_done[s] = 1;
        end
      end else if (alu_to_ac) begin
        m_acc[s] = int'(alu_out); m_c[s] = 0;
      end else if (write_en) begin
        m_acc[s] = int'(datain); m_c[s] = 0;
      end else if (clr_en) begin
        m_acc[s] = 0; m_c[s] = 0;
      end else if (shift_start) begin
        if (shift_amt == 3'd0) m_done[s] = 1;
        else begin
          m_rem[s] = int'(shift_amt);
          m_dir[s] = int'(shift_dir);
        end
      end else if (inc_en && !dec_en) begin
        if (m_acc[s] == 255) begin
          m_c[s] = 1;
          if (s == 0) m_acc[s] = 0;
        end else begin
          m_acc[s]++; m_c[s] = 0;
        end
      end else if (dec_en && !inc_en) begin
        if (m_acc[s] == 0) begin
          m_c[s] = 1;
          if (s == 0) m_acc[s] = 255;
        end else begin
          m_acc[s]--; m_c[s] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("s%0d_dataout", s), 32'(dout[s]), 32'(m_acc[s]));
      chk($sformatf("s%0d_r_out", s),   32'(rout[s]), 32'(m_r[s]));
      chk($sformatf("s%0d_z_flag", s),  32'(z[s]),    32'(m_acc[s] == 0));
      chk($sformatf("s%0d_c_flag", s),  32'(c[s]),    32'(m_c[s]));
      chk($sformatf("s%0d_busy", s),    32'(bsy[s]),  32'(m_rem[s] > 0));
      chk($sformatf("s%0d_done", s),    32'(dn[s]),   32'(m_done[s]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    step_model();
    #1;
    check_all();
  endtask

  task automatic idle();
    write_en = 0; alu_to_ac = 0; inc_en = 0; dec_en = 0; clr_en = 0;
    shift_start = 0; shift_dir = 0; shift_amt = 3'd0; read_en = 4'd0;
    datain = 8'h00; alu_out = 8'h00;
  endtask

  task automatic do_write(input logic [7:0] v);
    idle(); write_en = 1; datain = v; cycle(); idle();
  endtask

  task automatic start_shift(input logic d, input logic [2:0] k);
    idle(); shift_start = 1; shift_dir = d; shift_amt = k; cycle(); idle();
  endtask

  initial begin
    rst = 1;
    idle();
    reset_model();
    #2;
    check_all();
    chk("reset_async_z", 32'(z[0]), 32'd1);
    cycle();
    rst = 0;

    // Wrap on increment from all-ones; saturating unit holds.
    do_write(8'hFF);
    inc_en = 1; cycle(); idle();
    chk("wrap_inc_val", 32'(dout[0]), 32'h00);
    chk("wrap_inc_c",   32'(c[0]),    32'd1);
    chk("wrap_inc_z",   32'(z[0]),    32'd1);
    chk("sat_inc_hold", 32'(dout[1]), 32'hFF);

    // Saturating decrement at zero, then increment.
    do_write(8'h00);
    dec_en = 1; cycle(); idle();
    chk("sat_dec_val", 32'(dout[1]), 32'h00);
    chk("sat_dec_c",   32'(c[1]),    32'd1);
    inc_en = 1; cycle(); idle();
    chk("sat_inc_val", 32'(dout[1]), 32'h01);
    chk("sat_inc_c",   32'(c[1]),    32'd0);

    // inc and dec together leave state alone.
    inc_en = 1; dec_en = 1; cycle(); idle();
    chk("incdec_hold", 32'(dout[1]), 32'h01);

    // Left shift by 3; dir/amt changes during the shift must not matter.
    do_write(8'h81);
    start_shift(1'b0, 3'd3);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) begin
        shift_dir = 1; shift_amt = 3'd7; write_en = 1; inc_en = 1; shift_start = 1; datain = 8'hAA;
        cycle(); idle();
      end
      chk($sformatf("shl_busy_c%0d", i), 32'(bsy[0]), 32'(i <= 3));
      chk($sformatf("shl_done_c%0d", i), 32'(dn[0]),  32'(i == 4));
      if (i == 4) begin
        chk("shl_val", 32'(dout[0]), 32'h08);
        chk("shl_c",   32'(c[0]),    32'd0);
      end
    end

    // Right shift by 2.
    do_write(8'h85);
    start_shift(1'b1, 3'd2);
    cycle(); cycle();
    chk("shr_val", 32'(dout[0]), 32'h21);
    chk("shr_done", 32'(dn[0]), 32'd1);

    // Zero-length shift.
    start_shift(1'b0, 3'd0);
    chk("sh0_done", 32'(dn[0]), 32'd1);
    chk("sh0_busy", 32'(bsy[0]), 32'd0);
    chk("sh0_val", 32'(dout[0]), 32'h21);
    cycle();
    chk("sh0_done_once", 32'(dn[0]), 32'd0);

    // Clear aborts a shift in its second cycle.
    do_write(8'h81);
    start_shift(1'b0, 3'd3);
    cycle();
    clr_en = 1; cycle(); idle();
    chk("abort_val",  32'(dout[0]), 32'h00);
    chk("abort_busy", 32'(bsy[0]),  32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("abort_no_done", 32'(dn[0]), 32'd0);
    end

    // Priority: alu_to_ac wins over write and clear.
    alu_to_ac = 1; write_en = 1; clr_en = 1; alu_out = 8'h3C; datain = 8'hC3;
    cycle(); idle();
    chk("prio_alu", 32'(dout[0]), 32'h3C);

    // R capture during an active shift.
    do_write(8'h81);
    start_shift(1'b0, 3'd3);
    read_en = 4'd13; datain = 8'h5A; cycle(); idle();
    chk("r_capture", 32'(rout[0]), 32'h5A);
    cycle(); cycle();
    chk("r_shift_val",  32'(dout[0]), 32'h08);
    chk("r_shift_done", 32'(dn[0]),   32'd1);

    // Reset mid-shift.
    start_shift(1'b0, 3'd3);
    cycle();
    rst = 1;
    #1;
    reset_model();
    chk("rst_mid_val",  32'(dout[0]), 32'h00);
    chk("rst_mid_r",    32'(rout[0]), 32'h00);
    chk("rst_mid_busy", 32'(bsy[0]),  32'd0);
    check_all();
    cycle();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rst_no_done", 32'(dn[0]), 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      alu_to_ac   = ($urandom_range(0, 9) == 0);
      write_en    = ($urandom_range(0, 7) == 0);
      clr_en      = ($urandom_range(0, 11) == 0);
      shift_start = ($urandom_range(0, 5) == 0);
      inc_en      = ($urandom_range(0, 2) == 0);
      dec_en      = ($urandom_range(0, 2) == 0);
      shift_dir   = 1'($urandom_range(0, 1));
      shift_amt   = 3'($urandom_range(0, 7));
      read_en     = ($urandom_range(0, 3) == 0) ? 4'd13 : 4'($urandom_range(0, 15));
      datain      = 8'($urandom_range(0, 255));
      alu_out     = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) datain = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      cycle();
    end
    rst = 0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 Parameter N, default 16: accumulator and bus width; legal range 4..64.
REQ-002 Parameter SAT, default 0: 0 = inc/dec wrap around, 1 = inc/dec saturate.
REQ-003 Parameter R_ID, default 4'd13: read_en code that captures datain into r_out.
REQ-004 Parameter SW = $clog2(N): width of shift_amt.
REQ-005 Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_en  in  1  load accumulator from datain.
- read_en  in  4  register-select code from the control unit.
- datain  in  N  bus input.
- alu_out  in  N  ALU result.
- alu_to_ac  in  1  load accumulator from alu_out.
- inc_en  in  1  increment accumulator.
- dec_en  in  1  decrement accumulator.
- clr_en  in  1  clear accumulator; also aborts a shift.
- shift_start  in  1  start a multi-cycle shift.
- shift_dir  in  1  0 = logical left, 1 = logical right.
- shift_amt  in  SW  number of bit positions to shift.
- dataout  out  N  accumulator value, driven to the bus.
- r_out  out  N  R register.
- z_flag  out  1  combinational, dataout == 0.
- c_flag  out  1  registered carry/borrow/shift-out flag.
- busy  out  1  high while a shift is in progress.
- done  out  1  one-cycle pulse when a shift completes.

Function
REQ-006 States: IDLE, SHIFT. busy SHALL be 1 exactly when the state is SHIFT.
REQ-007 In IDLE, exactly one accumulator operation SHALL take effect per cycle, in this priority: alu_to_ac > write_en > clr_en > shift_start > inc_en/dec_en.
REQ-008 alu_to_ac, write_en and clr_en SHALL load alu_out, datain and 0 respectively, and SHALL set c_flag to 0.
REQ-009 When inc_en and dec_en are both asserted without any higher-priority op, the accumulator and c_flag SHALL be unchanged.
REQ-010 Inc with SAT=0: acc+1 modulo 2^N; c_flag = 1 on wrap from all-ones to 0, else 0.
REQ-011 Inc with SAT=1: an all-ones accumulator SHALL hold and set c_flag=1; otherwise acc+1 with c_flag=0.
REQ-012 Dec with SAT=0: acc-1 modulo 2^N; c_flag = 1 on borrow from 0 to all-ones, else 0.
REQ-013 Dec with SAT=1: a zero accumulator SHALL hold and set c_flag=1; otherwise acc-1 with c_flag=0.
REQ-014 shift_start in IDLE with shift_amt = 0 SHALL leave the accumulator and c_flag unchanged, stay in IDLE, and pulse done in the next cycle.
REQ-015 shift_start in IDLE with shift_amt = k > 0 SHALL latch shift_dir and k and enter SHIFT.
- In SHIFT: one-bit shift per cycle, zero fill, c_flag = the bit shifted out.
- After k shift cycles: return to IDLE, and done = 1 for exactly the cycle following the last shift.
- Total latency from the shift_start edge to done: k+1 cycles.
REQ-016 In SHIFT, clr_en SHALL abort the shift: acc=0, c_flag=0, state IDLE, no done pulse.
REQ-017 In SHIFT, alu_to_ac, write_en, inc_en, dec_en and shift_start SHALL be ignored.
REQ-018 r_out SHALL load datain on any cycle where read_en == R_ID, independent of state and of all other operations.
REQ-019 Changes to shift_dir and shift_amt during SHIFT SHALL have no effect.

Reset
REQ-020 While rst=1, regardless of clk: dataout=0, r_out=0, c_flag=0, state IDLE, busy=0, done=0; z_flag therefore reads 1.
REQ-021 Reset asserted during SHIFT SHALL abandon the shift with no done pulse; operation resumes on the first clk edge after deassertion.

Verification
REQ-022 N=8, SAT=0: write 8'hFF, then inc -> dataout=8'h00, c_flag=1, z_flag=1.
REQ-023 N=8, SAT=1: write 8'h00, then dec -> dataout=8'h00, c_flag=1; then inc -> 8'h01, c_flag=0.
REQ-024 N=8: write 8'h81, shift_start with dir=0, amt=3 -> busy for 3 cycles, dataout=8'h08, c_flag=0, done pulses once at cycle 4.
REQ-025 Same shift with clr_en asserted in shift cycle 2 -> dataout=0, busy=0, done never asserted; alu_to_ac+write_en+clr_en in one cycle -> alu_out loaded.
REQ-026 read_en=13 with datain=8'h5A during an active shift -> r_out=8'h5A, shift unaffected; rst pulsed mid-shift -> all outputs 0, no done pulse.
